spi_target_ep: RTL and testbench



---
 rtl/spi_target_pkg.sv | 16 +
 rtl/spi_target_sync_edge.sv | 35 +++
 rtl/spi_target_ep.sv | 144 ++++++++++++++
 tb/tb_spi_target_ep.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target endpoint.
//   state_t           : FSM encoding (T_IDLE=0, T_LOAD=1, T_SHIFT=2)
//   FILL_BYTE_DEFAULT : byte sent on miso when the tx stream is empty
//   SYNC_DEPTH        : synchronizer flops per asynchronous SPI pin
package spi_target_pkg;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_LOAD  = 2'd1,
    T_SHIFT = 2'd2
  } state_t;

  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;
  localparam int         SYNC_DEPTH        = 2;

endpackage

// File: rtl/spi_target_sync_edge.sv
// 1-bit synchronizer with edge detection for an asynchronous SPI pin.
//   clk, reset : system clock, synchronous active-high reset
//   din        : asynchronous input
//   rise, fall : one-cycle pulses on the synchronized input's edges
// Flops reset to 0, so a pin that is already low at reset release never
// produces a fall pulse; it has to go high and then low again.
module spi_sync_edge
  import spi_target_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync_ff;
  logic                  sync;
  logic                  prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff <= '0;
      prev    <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_DEPTH-2:0], din};
      prev    <= sync;
    end
  end

  assign sync = sync_ff[SYNC_DEPTH-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_target_ep.sv
// SPI target, mode 0, MSB first, oversampled on clk.
//   spi_cs_b/spi_sck/spi_mosi : asynchronous pins from the external master
//   spi_miso, spi_miso_oe     : reply data and its output enable
//   rx_data_free/put/rx_data  : put-style stream of received bytes
//   tx_data_avail/get/tx_data : get-style stream of reply bytes
//   xfr_active, xfr_done      : transfer framing status
//   xfr_bytes                 : completed bytes of current/last transfer
//   rx_overflow               : sticky, a received byte was dropped
module spi_target_ep
  import spi_target_pkg::*;
#(
  parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEFAULT,
  parameter int         CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_cs_b,
  input  logic                 spi_sck,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  input  logic                 rx_data_free,
  output logic                 rx_data_put,
  output logic [7:0]           rx_data,
  input  logic                 tx_data_avail,
  output logic                 tx_data_get,
  input  logic [7:0]           tx_data,
  output logic                 xfr_active,
  output logic                 xfr_done,
  output logic [CNT_WIDTH-1:0] xfr_bytes,
  output logic                 rx_overflow
);

  state_t                state;
  logic [2:0]            bit_cnt;
  logic [7:0]            shift_rx, shift_tx, tx_next;
  logic                  boundary;   // next sck fall starts a new tx byte
  logic [SYNC_DEPTH-1:0] mosi_ff;
  logic                  mosi_s;
  logic                  cs_rise, cs_fall, sck_rise, sck_fall;
  logic                  byte_end;
  logic [7:0]            rx_byte, tx_load;

  spi_sync_edge u_cs  (.clk, .reset, .din(spi_cs_b), .rise(cs_rise),  .fall(cs_fall));
  spi_sync_edge u_sck (.clk, .reset, .din(spi_sck),  .rise(sck_rise), .fall(sck_fall));

  always_ff @(posedge clk) begin
    if (reset) mosi_ff <= '0;
    else       mosi_ff <= {mosi_ff[SYNC_DEPTH-2:0], spi_mosi};
  end
  assign mosi_s = mosi_ff[SYNC_DEPTH-1];

  // sck edges only matter in T_SHIFT, which is only occupied while cs_b is
  // low (plus the cs_b rise cycle, so a coincident byte still completes).
  assign rx_byte  = {shift_rx[6:0], mosi_s};
  assign byte_end = (state == T_SHIFT) && sck_rise && (bit_cnt == 3'd7);
  assign tx_load  = tx_data_avail ? tx_data : FILL_BYTE;

  // Combinational so the stream pops the same byte that is captured here.
  assign tx_data_get = !reset && tx_data_avail &&
                       (((state == T_LOAD) && !cs_rise) || byte_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= T_IDLE;
      bit_cnt     <= '0;
      shift_rx    <= '0;
      shift_tx    <= '0;
      tx_next     <= '0;
      boundary    <= 1'b0;
      rx_data_put <= 1'b0;
      rx_data     <= '0;
      xfr_done    <= 1'b0;
      xfr_active  <= 1'b0;
      xfr_bytes   <= '0;
      rx_overflow <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      rx_data_put <= 1'b0;
      xfr_done    <= 1'b0;
      case (state)
        T_IDLE: begin
          spi_miso_oe <= 1'b0;
          if (cs_fall) begin
            state       <= T_LOAD;
            xfr_bytes   <= '0;
            rx_overflow <= 1'b0;
            xfr_active  <= 1'b1;
          end
        end
        T_LOAD: begin
          if (cs_rise) begin
            xfr_done   <= 1'b1;
            xfr_active <= 1'b0;
            state      <= T_IDLE;
          end else begin
            shift_tx    <= tx_load;
            spi_miso    <= tx_load[7];
            spi_miso_oe <= 1'b1;
            bit_cnt     <= '0;
            boundary    <= 1'b0;
            state       <= T_SHIFT;
          end
        end
        T_SHIFT: begin
          if (sck_rise) begin
            shift_rx <= rx_byte;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_data_free) begin
                rx_data_put <= 1'b1;
                rx_data     <= rx_byte;
              end else begin
                rx_overflow <= 1'b1;
              end
              if (xfr_bytes != '1) xfr_bytes <= xfr_bytes + CNT_WIDTH'(1);
              tx_next  <= tx_load;
              boundary <= 1'b1;
            end
          end else if (sck_fall) begin
            if (boundary) begin
              shift_tx <= tx_next;
              spi_miso <= tx_next[7];
              boundary <= 1'b0;
            end else begin
              shift_tx <= {shift_tx[6:0], 1'b0};
              spi_miso <= shift_tx[6];
            end
          end
          // A partial byte is simply abandoned; a prefetched tx byte is lost.
          if (cs_rise) begin
            xfr_done    <= 1'b1;
            xfr_active  <= 1'b0;
            spi_miso_oe <= 1'b0;
            state       <= T_IDLE;
          end
        end
        default: state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_target_ep.sv
// Bench for spi_target_ep: drives an SPI master at sck = clk/8 with minimum
// cs setup/hold, models the tx stream as a queue, and checks rx puts through
// a scoreboard monitor decoupled from the stimulus.
module tb_spi_target_ep;

  logic        clk = 1'b0, reset = 1'b1;
  logic        spi_cs_b = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe;
  logic        rx_data_free = 1'b1, rx_data_put;
  logic [7:0]  rx_data;
  logic        tx_data_avail = 1'b0, tx_data_get;
  logic [7:0]  tx_data = 8'h00;
  logic        xfr_active, xfr_done;
  logic [15:0] xfr_bytes;
  logic        rx_overflow;

  spi_target_ep dut (
    .clk(clk), .reset(reset),
    .spi_cs_b(spi_cs_b), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .rx_data_free(rx_data_free), .rx_data_put(rx_data_put), .rx_data(rx_data),
    .tx_data_avail(tx_data_avail), .tx_data_get(tx_data_get), .tx_data(tx_data),
    .xfr_active(xfr_active), .xfr_done(xfr_done), .xfr_bytes(xfr_bytes),
    .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  int         n_tests = 0, n_fail = 0;
  int         n_get = 0, n_done = 0;
  logic [7:0] exp_q[$];
  logic [7:0] txq[$];
  logic       tx_en = 1'b1;
  logic       get_seen = 1'b0;
  logic [7:0] mo_arr[256], mi_arr[256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    get_seen = tx_data_get;
    if (tx_data_get) begin
      n_get++;
      if (!tx_data_avail) check("get_without_avail", 32'(tx_data_get), 32'(tx_data_avail));
    end
    if (xfr_done) n_done++;
    if (rx_data_put) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rx_put: got unexpected byte %0h, expected no put", rx_data);
      end else begin
        check("rx_put", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // tx stream model: pop the byte the DUT consumed on the previous cycle.
  always @(posedge clk) begin
    #1;
    if (get_seen && txq.size() > 0) void'(txq.pop_front());
    tx_data_avail = tx_en && (txq.size() > 0);
    tx_data       = (txq.size() > 0) ? txq[0] : 8'h00;
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One mode-0 bit: data set while sck low, miso sampled on the rising edge.
  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    wclk(4);
    spi_sck = 1'b1;
    m = spi_miso;
    wclk(4);
    spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) begin
      logic m;
      spi_bit(mo[i], m);
      mi[i] = m;
    end
  endtask

  task automatic cs_end();
    wclk(4);
    spi_cs_b = 1'b1;
    wclk(8);
  endtask

  task automatic xfer(input int n, input string tag);
    logic [7:0] got;
    int d0;
    d0 = n_done;
    spi_cs_b = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mo_arr[i]);
      spi_byte(mo_arr[i], got);
      check({tag, "_miso"}, 32'(got), 32'(mi_arr[i]));
    end
    cs_end();
    check({tag, "_bytes"}, 32'(xfr_bytes), 32'(n));
    check({tag, "_done_pulses"}, 32'(n_done - d0), 32'd1);
    check({tag, "_active_low"}, 32'(xfr_active), 32'd0);
  endtask

  initial begin
    logic [7:0] got;
    logic       m;
    logic [4:0] part;
    int g0, d0;

    // Reset values
    wclk(3);
    check("rst_put", 32'(rx_data_put), 0);
    check("rst_get", 32'(tx_data_get), 0);
    check("rst_done", 32'(xfr_done), 0);
    check("rst_active", 32'(xfr_active), 0);
    check("rst_oe", 32'(spi_miso_oe), 0);
    check("rst_miso", 32'(spi_miso), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_bytes", 32'(xfr_bytes), 0);
    check("rst_ovf", 32'(rx_overflow), 0);
    reset = 1'b0;
    wclk(6);

    // Two-byte transfer
    txq.push_back(8'h5A); txq.push_back(8'hC3);
    wclk(2);
    mo_arr[0] = 8'hA5; mi_arr[0] = 8'h5A;
    mo_arr[1] = 8'h3C; mi_arr[1] = 8'hC3;
    g0 = n_get;
    xfer(2, "two_byte");
    check("two_byte_gets", 32'(n_get - g0), 32'd2);

    // Empty tx stream
    tx_en = 1'b0;
    wclk(2);
    mo_arr[0] = 8'h11; mo_arr[1] = 8'h22; mo_arr[2] = 8'h33;
    mi_arr[0] = 8'hFF; mi_arr[1] = 8'hFF; mi_arr[2] = 8'hFF;
    g0 = n_get;
    xfer(3, "empty_tx");
    check("empty_tx_gets", 32'(n_get - g0), 32'd0);
    tx_en = 1'b1;

    // Backpressure on byte 2
    txq.push_back(8'h10); txq.push_back(8'h20); txq.push_back(8'h30);
    wclk(2);
    d0 = n_done;
    spi_cs_b = 1'b0;
    exp_q.push_back(8'h01);
    spi_byte(8'h01, got); check("bp_miso0", 32'(got), 32'h10);
    rx_data_free = 1'b0;
    spi_byte(8'h02, got); check("bp_miso1", 32'(got), 32'h20);
    rx_data_free = 1'b1;
    exp_q.push_back(8'h03);
    spi_byte(8'h03, got); check("bp_miso2", 32'(got), 32'h30);
    cs_end();
    check("bp_overflow", 32'(rx_overflow), 32'd1);
    check("bp_bytes", 32'(xfr_bytes), 32'd3);
    check("bp_done_pulses", 32'(n_done - d0), 32'd1);

    // Aborted second byte; next cs fall clears overflow
    txq.push_back(8'h77); txq.push_back(8'h88);
    wclk(2);
    d0 = n_done;
    spi_cs_b = 1'b0;
    wclk(5);
    check("abort_ovf_cleared", 32'(rx_overflow), 32'd0);
    check("abort_active", 32'(xfr_active), 32'd1);
    exp_q.push_back(8'h96);
    spi_byte(8'h96, got); check("abort_miso0", 32'(got), 32'h77);
    for (int i = 4; i >= 0; i--) begin
      spi_bit(1'b1, m);
      part[i] = m;
    end
    check("abort_miso_partial", 32'(part), 32'h11);   // top 5 bits of 8'h88
    cs_end();
    check("abort_bytes", 32'(xfr_bytes), 32'd1);
    check("abort_done_pulses", 32'(n_done - d0), 32'd1);
    check("abort_no_partial_put", 32'(exp_q.size()), 32'd0);

    // Reset mid-transfer
    txq.push_back(8'hAA);
    wclk(2);
    spi_cs_b = 1'b0;
    for (int i = 0; i < 3; i++) spi_bit(1'b1, m);
    reset = 1'b1;
    wclk(1);
    check("mid_rst_active", 32'(xfr_active), 0);
    check("mid_rst_oe", 32'(spi_miso_oe), 0);
    check("mid_rst_miso", 32'(spi_miso), 0);
    check("mid_rst_rx_data", 32'(rx_data), 0);
    check("mid_rst_bytes", 32'(xfr_bytes), 0);
    check("mid_rst_put", 32'(rx_data_put), 0);
    spi_cs_b = 1'b1;
    wclk(2);
    reset = 1'b0;
    wclk(8);
    mo_arr[0] = 8'hF0; mi_arr[0] = 8'hFF;
    xfer(1, "after_rst");
    check("after_rst_data", 32'(rx_data), 32'hF0);

    // 256 bytes at minimum master timing
    for (int i = 0; i < 256; i++) begin
      mo_arr[i] = 8'(i);
      mi_arr[i] = 8'(i) ^ 8'h5C;
      txq.push_back(8'(i) ^ 8'h5C);
    end
    wclk(2);
    g0 = n_get;
    xfer(256, "long");
    check("long_gets", 32'(n_get - g0), 32'd256);

    wclk(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
